reg_bank_db: RTL
================

# reg_bank_db

Parametrised, double-buffered register bank replacing single fixed-width enabled registers. DEPTH channels of WIDTH bits each are written individually into a shadow bank and copied atomically into the active bank on a commit strobe. Consumers such as neuron weight or servo setpoint logic read a stable active set while a producer loads the next set. A registered read port and dirty/error status are provided.

## Interface
Parameters:
- WIDTH, 16, bits per channel (1..64)
- DEPTH, 8, number of channels (2..64, need not be a power of two)
- DOUBLE_BUF, 1, 1 = shadow+active banks; 0 = writes land directly in active, commit ignored
- RESET_VAL, 0, value of every shadow and active entry after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously upstream)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  channel index, ADDR_W = max(1, clog2(DEPTH))
- wr_data  in  WIDTH  write value
- commit  in  1  copy shadow to active
- clr  in  1  synchronous clear of shadow bank to RESET_VAL
- rd_addr  in  ADDR_W  read channel index
- rd_data  out  WIDTH  active[rd_addr], registered
- dirty  out  1  shadow differs in provenance from active (written/cleared since last commit)
- commit_done  out  1  one-cycle pulse after a commit takes effect
- wr_err  out  1  one-cycle pulse: write to wr_addr >= DEPTH dropped

## Operation
- Reset (rst low): all shadow and active entries = RESET_VAL; rd_data = RESET_VAL; dirty, commit_done, wr_err = 0.
- Write: wr_en with wr_addr < DEPTH sets shadow[wr_addr] = wr_data, sets dirty. wr_addr >= DEPTH: no state change, wr_err = 1 next cycle.
- clr: every shadow entry = RESET_VAL, sets dirty. clr with wr_en same cycle: the write wins for its entry, all others cleared.
- commit: active = shadow as it stood before this edge (every entry, same edge); dirty cleared; commit_done = 1 next cycle.
- commit with wr_en same cycle: active gets old shadow; write lands in shadow; dirty stays 1. Same rule for commit with clr.
- commit with dirty = 0: copy still performed (no-op), commit_done still pulses.
- DOUBLE_BUF = 0: shadow absent; write/clr act on active directly; commit only pulses commit_done; dirty tied 0.
- Read: rd_data <= active[rd_addr] each cycle; rd_addr >= DEPTH returns 0.

## Timing
- Write-to-shadow: 1 edge. Shadow-to-active: commit edge. Active-to-rd_data: 1 further edge.
- Write at edge N, commit at edge N+1, rd_data shows value after edge N+2.
- Read during commit edge returns pre-commit active value; next cycle returns new value.
- DOUBLE_BUF = 0: write at edge N visible on rd_data after edge N+1.
- rst asserted mid-sequence: all state returns to reset values immediately; pending commit lost; no commit_done pulse.
- commit held high continuously: copy every cycle, commit_done high continuously.

## Structure
- Shared package/include reg_bank_pkg: clog2 function, ADDR_W derivation, RESET_VAL default constant.
- Sub-module reg_bank_entry: one channel (shadow + active register, local write/clr/commit select), generated DEPTH times; top holds address decode, read mux, status flags.

## Test plan
- Reset: RESET_VAL=16'h00A5, release rst, read all 8 channels -> 16'h00A5 each, dirty=0.
- Write ch3=16'h1234, no commit, read ch3 -> old value; commit, read ch3 two cycles after write+commit -> 16'h1234, commit_done one pulse, dirty 1 -> 0.
- Same-cycle commit + write ch5=16'hBEEF (shadow ch5 previously 16'h0001) -> active ch5=16'h0001, dirty=1; second commit -> 16'hBEEF.
- DEPTH=6: write addr 7 -> wr_err one pulse, no entry changed; read addr 6 -> 0.
- clr + write ch0=16'h0F0F same cycle, commit -> ch0=16'h0F0F, ch1..7=RESET_VAL.
- rst low between write and commit -> all entries RESET_VAL, no commit_done; DOUBLE_BUF=0 build: write ch2=16'h5555 visible after 2 edges without commit.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared helpers for the double-buffered register bank: address-width
// derivation and the default reset value used by reg_bank_db.
package reg_bank_pkg;

  // Default value loaded into every shadow/active entry on reset.
  localparam logic [63:0] RESET_VAL_DEFAULT = 64'h0;

  // Ceiling log2, written as a bounded loop so it folds at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Address width for a bank of the given depth; never below one bit.
  function automatic int addr_w(input int depth);
    int w;
    w = clog2(depth);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// One channel of the register bank: a shadow register loaded by the producer
// and an active register copied from it on commit. With DOUBLE_BUF = 0 the
// shadow is held constant and writes/clears land on the active register.
module reg_bank_entry
  import reg_bank_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              DOUBLE_BUF = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_sel_i,
  input  logic             clr_i,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] active_o
);

  localparam bit DB_EN = (DOUBLE_BUF != 32'sd0);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] active_d;

  // Shadow next state: a write to this channel beats a bank-wide clear.
  always_comb begin
    shadow_d = shadow_q;
    if (!DB_EN) begin
      shadow_d = RESET_VAL;
    end else if (wr_sel_i) begin
      shadow_d = wr_data_i;
    end else if (clr_i) begin
      shadow_d = RESET_VAL;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Active next state: copy the pre-edge shadow on commit, or take
  // writes/clears directly when single-buffered.
  always_comb begin
    active_d = active_q;
    if (DB_EN) begin
      if (commit_i) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
    end else begin
      if (wr_sel_i) begin
        active_d = wr_data_i;
      end else if (clr_i) begin
        active_d = RESET_VAL;
      end else begin
        active_d = active_q;
      end
    end
  end

  // Channel storage, both banks returning to RESET_VAL on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= RESET_VAL;
      active_q <= RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/reg_bank_db.sv
// Double-buffered register bank. The producer writes channels into a shadow
// bank; a commit strobe copies the whole shadow into the active bank on one
// edge so consumers always read a consistent set. Holds the address decode,
// the registered read mux and the dirty/commit_done/wr_err status flags.
module reg_bank_db
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 8,
  parameter int               DOUBLE_BUF = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = RESET_VAL_DEFAULT[WIDTH-1:0],
  localparam int              ADDR_W     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              commit,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              dirty,
  output logic              commit_done,
  output logic              wr_err
);

  localparam bit              DB_EN   = (DOUBLE_BUF != 32'sd0);
  // Depth widened by one bit so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic              wr_addr_ok_s;
  logic              rd_addr_ok_s;
  logic              wr_hit_s;
  logic [WIDTH-1:0]  active_s [DEPTH];
  logic [WIDTH-1:0]  rd_mux_s;

  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  rd_data_d;
  logic              dirty_q;
  logic              dirty_d;
  logic              commit_done_q;
  logic              commit_done_d;
  logic              wr_err_q;
  logic              wr_err_d;

  assign wr_addr_ok_s = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_addr_ok_s = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_hit_s     = wr_en & wr_addr_ok_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic wr_sel_s;
    assign wr_sel_s = wr_hit_s & (wr_addr == ADDR_W'(i));

    reg_bank_entry #(
      .WIDTH      (WIDTH),
      .DOUBLE_BUF (DOUBLE_BUF),
      .RESET_VAL  (RESET_VAL)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .wr_sel_i  (wr_sel_s),
      .clr_i     (clr),
      .commit_i  (commit),
      .wr_data_i (wr_data),
      .active_o  (active_s[i])
    );
  end

  // Read mux over the active bank; addresses past the last channel read 0.
  always_comb begin
    rd_mux_s = '0;
    if (rd_addr_ok_s) begin
      rd_mux_s = active_s[rd_addr];
    end else begin
      rd_mux_s = '0;
    end
  end

  // Status next state: any accepted write or clear marks the shadow dirty,
  // even when it coincides with a commit that clears the flag.
  always_comb begin
    rd_data_d     = rd_mux_s;
    commit_done_d = commit;
    wr_err_d      = wr_en & ~wr_addr_ok_s;
    dirty_d       = dirty_q;
    if (!DB_EN) begin
      dirty_d = 1'b0;
    end else if (wr_hit_s || clr) begin
      dirty_d = 1'b1;
    end else if (commit) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // Registered read data and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q     <= RESET_VAL;
      dirty_q       <= 1'b0;
      commit_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      dirty_q       <= dirty_d;
      commit_done_q <= commit_done_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign dirty       = dirty_q;
  assign commit_done = commit_done_q;
  assign wr_err      = wr_err_q;

endmodule
